fec_codec_stream: RTL and testbench

- Streaming, handshaked successor to the combinational FEC codec for cyclic-shift network coding.
- Accepts a block of M coded or lifted symbols, one per beat, into an internal buffer.
- Applies the encode matrix, the decode matrix, or decode-then-encode, and emits M result symbols with valid/ready backpressure.
- Coefficient matrices live in internal registers, loaded through a write port; sits between packet parser and payload sink.

---
 rtl/fec_pkg.sv | 42 ++++
 rtl/fec_codec_stream_row_mac.sv | 25 ++
 rtl/fec_codec_stream.sv | 164 ++++++++++++++++
 tb/tb_fec_codec_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fec_pkg.sv
// Shared types and ring arithmetic for the cyclic-shift FEC stream codec.
// Ring is GF(2)[x]/(x^width+1); products are computed on a fixed-width carrier.
package fec_pkg;

    localparam int CYC_MAX_W = 64;

    typedef enum logic [1:0] {
        FEC_ENC    = 2'd0,
        FEC_DEC    = 2'd1,
        FEC_CHAIN  = 2'd2,
        FEC_BYPASS = 2'd3
    } fec_mode_e;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        XFORM   = 2'd1,
        EMIT    = 2'd2
    } fec_state_e;

    // XOR of a rotated left by every set bit position of b, rotation taken modulo width.
    function automatic logic [CYC_MAX_W-1:0] cyc_mul(
        input logic [CYC_MAX_W-1:0] a,
        input logic [CYC_MAX_W-1:0] b,
        input int                   width
    );
        logic [CYC_MAX_W-1:0] acc;
        logic [5:0]           idx;
        acc = '0;
        for (int i = 0; i < CYC_MAX_W; i++) begin
            if (i < width && b[i]) begin
                for (int k = 0; k < CYC_MAX_W; k++) begin
                    if (k < width) begin
                        idx      = 6'((k + i) % width);
                        acc[idx] = acc[idx] ^ a[k];
                    end
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fec_codec_stream_row_mac.sv
// One matrix row applied to the symbol buffer: XOR over columns of coef*symbol.
// Purely combinational, no handshake.
module fec_row_mac import fec_pkg::*; #(
    parameter int M     = 3,
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0] coefs  [M],
    input  logic [WIDTH-1:0] sym    [M],
    output logic [WIDTH-1:0] result
);

    logic [CYC_MAX_W-1:0] acc;
    logic                 unused_hi;

    always_comb begin
        acc = '0;
        for (int c = 0; c < M; c++) begin
            acc = acc ^ cyc_mul(CYC_MAX_W'(coefs[c]), CYC_MAX_W'(sym[c]), WIDTH);
        end
    end

    assign result    = acc[WIDTH-1:0];
    assign unused_hi = ^acc[CYC_MAX_W-1:WIDTH];

endmodule

// File: rtl/fec_codec_stream.sv
// Block FEC codec: collect M symbols, apply encode/decode/chain/bypass, emit M results.
// Latency: first result 1 cycle after the closing beat (M+1 for CHAIN); one row per beat after.
// Backpressure: out_ready stalls EMIT holding data; in_ready low outside COLLECT. FEC_STREAM_UNLIFT_CHECK_EN adds lift-error flags.
module fec_codec_stream import fec_pkg::*; #(
    parameter int M     = 3,
    parameter int WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    input  logic                 coef_we,
    input  logic                 coef_sel,
    input  logic [$clog2(M)-1:0] coef_row,
    input  logic [$clog2(M)-1:0] coef_col,
    input  logic [WIDTH-1:0]     coef_data,
    output logic                 coef_ready
`ifdef FEC_STREAM_UNLIFT_CHECK_EN
    ,
    output logic                 out_lift_err,
    output logic                 lift_err_seen
`endif
);

    localparam int RW     = $clog2(M);
    localparam int DATA_W = WIDTH - 1;

    if (M < 2 || DATA_W < 1) begin : g_bad_param
        $error("fec_codec_stream: M must be >= 2 and WIDTH >= 2");
    end

    fec_state_e       state;
    fec_mode_e        mode_q;
    fec_mode_e        blk_mode;
    logic [RW-1:0]    count;
    logic [RW-1:0]    row;
    logic [WIDTH-1:0] enc_m   [M][M];
    logic [WIDTH-1:0] dec_m   [M][M];
    logic [WIDTH-1:0] buf_q   [M];
    logic [WIDTH-1:0] mid_q   [M];
    logic [WIDTH-1:0] sel_coef[M];
    logic [WIDTH-1:0] mac_out;
    logic [WIDTH-1:0] emit_val;
    logic             in_fire;
    logic             closing;
    logic             load_out;
    logic             finish;
    logic             coef_fire;

    assign in_ready   = (state == COLLECT);
    assign coef_ready = (state == COLLECT) && (count == '0);
    assign in_fire    = in_valid && in_ready;
    assign closing    = in_fire && ((count == RW'(M - 1)) || in_last);
    assign blk_mode   = (count == '0) ? fec_mode_e'(mode) : mode_q;
    assign load_out   = (state == EMIT) && (!out_valid || (out_ready && !out_last));
    assign finish     = (state == EMIT) && out_valid && out_ready && out_last;
    assign coef_fire  = coef_we && coef_ready
                        && ({1'b0, coef_row} < (RW + 1)'(M))
                        && ({1'b0, coef_col} < (RW + 1)'(M));

    // XFORM always walks the decode matrix; EMIT picks by latched mode (CHAIN re-encodes).
    always_comb begin
        sel_coef = enc_m[row];
        if (state == XFORM || mode_q == FEC_DEC) begin
            sel_coef = dec_m[row];
        end
    end

    fec_row_mac #(.M(M), .WIDTH(WIDTH)) u_mac (
        .coefs  (sel_coef),
        .sym    (buf_q),
        .result (mac_out)
    );

    assign emit_val = (mode_q == FEC_BYPASS) ? buf_q[row] : mac_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            mode_q    <= FEC_ENC;
            count     <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            for (int r = 0; r < M; r++) begin
                buf_q[r] <= '0;
                mid_q[r] <= '0;
                for (int c = 0; c < M; c++) begin
                    enc_m[r][c] <= (r == c) ? WIDTH'(1) : '0;
                    dec_m[r][c] <= (r == c) ? WIDTH'(1) : '0;
                end
            end
        end else begin
            if (coef_fire) begin
                if (coef_sel) dec_m[coef_row][coef_col] <= coef_data;
                else          enc_m[coef_row][coef_col] <= coef_data;
            end
            case (state)
                COLLECT: begin
                    if (in_fire) begin
                        // First beat wipes the buffer so a short block leaves zeros behind it.
                        if (count == '0) begin
                            mode_q <= blk_mode;
                            for (int i = 0; i < M; i++) buf_q[i] <= '0;
                        end
                        buf_q[count] <= in_data;
                        if (closing) begin
                            row   <= '0;
                            state <= (blk_mode == FEC_CHAIN) ? XFORM : EMIT;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                XFORM: begin
                    mid_q[row] <= mac_out;
                    row        <= row + 1'b1;
                    if (row == RW'(M - 1)) begin
                        for (int i = 0; i < M; i++) buf_q[i] <= mid_q[i];
                        buf_q[row] <= mac_out;
                        row        <= '0;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (finish) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        count     <= '0;
                        state     <= COLLECT;
                    end else if (load_out) begin
                        out_data  <= emit_val;
                        out_last  <= (row == RW'(M - 1));
                        out_valid <= 1'b1;
                        row       <= row + 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef FEC_STREAM_UNLIFT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_lift_err  <= 1'b0;
            lift_err_seen <= 1'b0;
        end else begin
            if (load_out) out_lift_err <= (mode_q == FEC_CHAIN) && emit_val[DATA_W];
            else if (finish) out_lift_err <= 1'b0;
            if (out_valid && out_lift_err) lift_err_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fec_codec_stream.sv
// Randomised + directed bench for fec_codec_stream against a polynomial-arithmetic model.
module tb_fec_codec_stream;

    localparam int M  = 3;
    localparam int W  = 11;
    localparam int RW = 2;

    typedef logic [W-1:0] vec_t [M];
    typedef logic [W-1:0] mat_t [M][M];
    typedef struct {
        logic [W-1:0] d;
        logic         last;
        logic         lerr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          in_valid, in_ready, in_last;
    logic [W-1:0]  in_data;
    logic          out_valid, out_last;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          coef_we, coef_sel, coef_ready;
    logic [RW-1:0] coef_row, coef_col;
    logic [W-1:0]  coef_data;
`ifdef FEC_STREAM_UNLIFT_CHECK_EN
    logic          out_lift_err, lift_err_seen;
`endif

    fec_codec_stream #(.M(M), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .coef_we(coef_we), .coef_sel(coef_sel), .coef_row(coef_row), .coef_col(coef_col),
        .coef_data(coef_data), .coef_ready(coef_ready)
`ifdef FEC_STREAM_UNLIFT_CHECK_EN
        , .out_lift_err(out_lift_err), .lift_err_seen(lift_err_seen)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   ready_ctl = 1;  // 0 random, 1 high, 2 low
    int   close_cyc = 0;
    int   exp_lat = 1;
    bit   lat_pending = 0;
    bit   model_seen = 0;
    exp_t expq[$];
    mat_t menc, mdec;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        if (ready_ctl == 0)      out_ready = ($urandom_range(0, 3) != 0);
        else if (ready_ctl == 1) out_ready = 1'b1;
        else                     out_ready = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, req);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (timeout or unexpected event)", nm);
    endtask

    // Ring product as a full polynomial product folded with x^W == 1.
    function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
        return p[W-1:0] ^ p[2*W-1:W];
    endfunction

    function automatic void mat_vec(input mat_t mt, input vec_t v, output vec_t r);
        for (int i = 0; i < M; i++) begin
            r[i] = '0;
            for (int c = 0; c < M; c++) r[i] = r[i] ^ gmul(mt[i][c], v[c]);
        end
    endfunction

    function automatic void model_out(input int md, input vec_t v, output vec_t r);
        vec_t t;
        case (md)
            0: mat_vec(menc, v, r);
            1: mat_vec(mdec, v, r);
            2: begin mat_vec(mdec, v, t); mat_vec(menc, t, r); end
            default: r = v;
        endcase
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                menc[r][c] = (r == c) ? W'(1) : W'(0);
                mdec[r][c] = (r == c) ? W'(1) : W'(0);
            end
        model_seen = 0;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (lat_pending) begin
                chk("first_out_latency", cyc - close_cyc, exp_lat);
                lat_pending = 0;
            end
            if (expq.size() == 0) flag("unexpected_out_valid");
            else begin
                chk("out_data", out_data, expq[0].d);
                chk("out_last", out_last, expq[0].last);
`ifdef FEC_STREAM_UNLIFT_CHECK_EN
                chk("out_lift_err", out_lift_err, expq[0].lerr);
`endif
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic coef_wr(input bit sel, input int r, input int c, input logic [W-1:0] d, input bit take);
        coef_we = 1; coef_sel = sel; coef_row = RW'(r); coef_col = RW'(c); coef_data = d;
        @(posedge clk); #1;
        coef_we = 0;
        if (take && r < M && c < M) begin
            if (sel) mdec[r][c] = d;
            else     menc[r][c] = d;
        end
    endtask

    task automatic send_block(input int md, input vec_t v, input int n, input bit wild, output vec_t res);
        vec_t full;
        exp_t e;
        int   t;
        for (int i = 0; i < M; i++) full[i] = (i < n) ? v[i] : W'(0);
        model_out(md, full, res);
        for (int i = 0; i < M; i++) begin
            e.d = res[i]; e.last = (i == M - 1); e.lerr = (md == 2) && res[i][W-1];
            if (e.lerr) model_seen = 1;
            expq.push_back(e);
        end
        for (int b = 0; b < n; b++) begin
            if (wild) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_valid = 1; in_data = v[b];
            in_last  = (b == n - 1) ? ((n < M) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            mode     = (b == 0 || !wild) ? 2'(md) : 2'($urandom_range(0, 3));
            t = 0;
            while (1) begin
                @(negedge clk);
                if (in_ready) break;
                if (++t > 200) begin flag("in_ready_wait"); break; end
            end
            @(posedge clk); #1;
            in_valid = 0; in_last = 0;
        end
        close_cyc   = cyc;
        exp_lat     = (md == 2) ? M + 1 : 1;
        lat_pending = 1;
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 500) begin @(negedge clk); t++; end
        if (expq.size() != 0) begin flag("drain"); expq.delete(); end
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_coef_ready", coef_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        if (!out_valid) flag("wait_out_valid");
    endtask

    task automatic pin(input string nm, input vec_t got, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        chk({nm, "_r0"}, got[0], a);
        chk({nm, "_r1"}, got[1], b);
        chk({nm, "_r2"}, got[2], c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, res;
        mat_t enc_lit, dec_lit;
        enc_lit = '{'{11'd1, 11'd1, 11'd1}, '{11'd0, 11'd2, 11'd4}, '{11'd0, 11'd4, 11'd16}};
        dec_lit = '{'{11'd1, 11'd511, 11'd256}, '{11'd0, 11'd682, 11'd853}, '{11'd0, 11'd853, 11'd597}};
        rst = 1; mode = 0; in_valid = 0; in_last = 0; in_data = 0;
        coef_we = 0; coef_sel = 0; coef_row = 0; coef_col = 0; coef_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_coef_ready", coef_ready, 1);
        @(posedge clk); #1;

        v = '{11'd5, 11'd6, 11'd7};
        send_block(0, v, M, 0, res); pin("enc_identity", res, 5, 6, 7); drain();

        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                coef_wr(0, r, c, enc_lit[r][c], 1);
                coef_wr(1, r, c, dec_lit[r][c], 1);
            end
        coef_wr(0, 3, 0, 11'h7ff, 1);
        coef_wr(1, 0, 3, 11'h7ff, 1);

        v = '{11'd753, 11'd1000, 11'd748};
        send_block(1, v, M, 0, res); pin("dec", res, 1954, 305, 1122); drain();
        send_block(2, v, M, 0, res); pin("chain", res, 753, 1000, 748); drain();

        // Row 1 held for five cycles with out_ready low.
        ready_ctl = 2;
        v = '{11'd1954, 11'd305, 11'd1122};
        send_block(0, v, M, 0, res); pin("enc", res, 753, 1000, 748);
        wait_valid();
        @(posedge clk); #1 ready_ctl = 1;
        @(posedge clk); #1 ready_ctl = 2;
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, 1000);
        end
        @(posedge clk); #1 ready_ctl = 1;
        drain();

        v = '{11'd10, 11'd20, 11'd0};
        send_block(3, v, 2, 0, res); pin("bypass_short", res, 10, 20, 0); drain();

        // Coefficient write during EMIT must be dropped.
        v = '{11'd1954, 11'd305, 11'd1122};
        ready_ctl = 2;
        send_block(0, v, M, 0, res);
        wait_valid();
        chk("emit_coef_ready", coef_ready, 0);
        @(posedge clk); #1;
        coef_wr(0, 0, 0, 11'd2, 0);
        ready_ctl = 1;
        drain();
        send_block(0, v, M, 0, res); pin("enc_after_drop", res, 753, 1000, 748); drain();

        // Reset while in XFORM.
        v = '{11'd753, 11'd1000, 11'd748};
        send_block(2, v, M, 0, res);
        rst = 1; expq.delete(); lat_pending = 0; model_reset();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("xrst_out_valid", out_valid, 0);
        chk("xrst_in_ready", in_ready, 1);
        chk("xrst_coef_ready", coef_ready, 1);
        chk("xrst_out_data", out_data, 0);
        @(posedge clk); #1;
        v = '{11'd100, 11'd200, 11'd300};
        send_block(0, v, M, 0, res); pin("enc_after_rst", res, 100, 200, 300); drain();

        ready_ctl = 0;
        for (int blk = 0; blk < 40; blk++) begin
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 6))
                    coef_wr(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), W'($urandom), 1);
            for (int i = 0; i < M; i++) v[i] = W'($urandom);
            send_block($urandom_range(0, 3), v, ($urandom_range(0, 3) == 0) ? $urandom_range(1, M - 1) : M, 1, res);
            drain();
        end
`ifdef FEC_STREAM_UNLIFT_CHECK_EN
        chk("lift_err_seen", lift_err_seen, model_seen);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
